// File: rtl/interleaver_pkg.sv
// Shared constants and FSM state type for the convolutional-interleaver branch scheduler.
package interleaver_pkg;
  localparam int NUM_BRANCH = 12;
  localparam int DATA_W     = 8;
  localparam int SEL_W      = 4;
  localparam int PKT_LEN    = 204;
  localparam int MAX_MISS   = 4;
  localparam int CNT_W      = $clog2(PKT_LEN);
  localparam int MISS_W     = $clog2(MAX_MISS);

  typedef enum logic {HUNT, LOCK} state_t;
endpackage

// File: rtl/interleaver_branch_sched_if.sv
// Byte-stream in, branch-tagged byte stream out; slave is the scheduler, master its environment.
interface interleaver_branch_sched_if;
  import interleaver_pkg::*;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  in_sync;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_first;
  logic [NUM_BRANCH-1:0] branch_we;
  logic                  locked;
  logic                  sync_err;

  modport slave (
    input  in_valid, in_data, in_sync, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_first, branch_we, locked, sync_err
  );
  modport master (
    output in_valid, in_data, in_sync, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_first, branch_we, locked, sync_err
  );
endinterface

// File: rtl/intlv_mod_counter.sv
// Wrapping modulo-MOD counter. load0 restarts as if position 0 was just consumed (value 1).
module intlv_mod_counter #(
  parameter int MOD = 12,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic         load0,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (load0) cnt <= W'(1);
    else if (inc)   cnt <= (cnt == W'(MOD-1)) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/interleaver_branch_sched.sv
// 12-branch interleaver commutator: sync hunt/lock FSM, one output register, branch write decode.
// Optional flywheel over missed syncs when INTLV_SYNC_FLYWHEEL_EN is defined.
module interleaver_branch_sched
  import interleaver_pkg::*;
(
  input  logic clk,
  input  logic rst,
  interleaver_branch_sched_if.slave bus
);
  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic accept, emit, sel_zero, first_nxt, serr_nxt;
  logic cnt_inc, cnt_clr, cnt_load0;
`ifdef INTLV_SYNC_FLYWHEEL_EN
  logic              miss_inc, miss_clr;
  logic [MISS_W-1:0] miss_cnt;
`endif

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.locked   = (state == LOCK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    sel_zero  = 1'b0;
    first_nxt = 1'b0;
    serr_nxt  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load0 = 1'b0;
`ifdef INTLV_SYNC_FLYWHEEL_EN
    miss_inc  = 1'b0;
    miss_clr  = 1'b0;
`endif
    if (accept) begin
      case (state)
        HUNT: if (bus.in_sync) begin
          emit = 1'b1; sel_zero = 1'b1; first_nxt = 1'b1;
          cnt_load0 = 1'b1; state_nxt = LOCK;
        end
        LOCK: begin
          if (bus.in_sync) begin
            emit = 1'b1; sel_zero = 1'b1; first_nxt = 1'b1;
`ifdef INTLV_SYNC_FLYWHEEL_EN
            miss_clr = 1'b1;
`endif
            // out-of-place sync realigns the commutator to branch 0
            if (byte_cnt == '0) cnt_inc = 1'b1;
            else begin serr_nxt = 1'b1; cnt_load0 = 1'b1; end
          end else if (byte_cnt != '0) begin
            emit = 1'b1; cnt_inc = 1'b1;
          end else begin
`ifdef INTLV_SYNC_FLYWHEEL_EN
            if (miss_cnt == MISS_W'(MAX_MISS-1)) begin
              state_nxt = HUNT; cnt_clr = 1'b1; miss_clr = 1'b1;
            end else begin
              emit = 1'b1; sel_zero = 1'b1; first_nxt = 1'b1;
              cnt_inc = 1'b1; miss_inc = 1'b1;
            end
`else
            state_nxt = HUNT; cnt_clr = 1'b1;
`endif
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  intlv_mod_counter #(.MOD(NUM_BRANCH), .W(SEL_W)) u_sel_cnt (
    .clk(clk), .rst(rst), .inc(cnt_inc), .clr(cnt_clr), .load0(cnt_load0), .cnt(sel_cnt)
  );
  intlv_mod_counter #(.MOD(PKT_LEN), .W(CNT_W)) u_byte_cnt (
    .clk(clk), .rst(rst), .inc(cnt_inc), .clr(cnt_clr), .load0(cnt_load0), .cnt(byte_cnt)
  );
`ifdef INTLV_SYNC_FLYWHEEL_EN
  intlv_mod_counter #(.MOD(MAX_MISS), .W(MISS_W)) u_miss_cnt (
    .clk(clk), .rst(rst), .inc(miss_inc), .clr(miss_clr), .load0(1'b0), .cnt(miss_cnt)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      bus.out_first <= 1'b0;
      bus.sync_err  <= 1'b0;
    end else begin
      bus.sync_err <= serr_nxt;
      if (accept) begin
        bus.out_valid <= emit;
        if (emit) begin
          bus.out_data  <= bus.in_data;
          bus.out_sel   <= sel_zero ? '0 : sel_cnt;
          bus.out_first <= first_nxt;
        end
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  assign bus.branch_we = (bus.out_valid && bus.out_ready && bus.locked)
                       ? (NUM_BRANCH'(1) << bus.out_sel) : '0;
endmodule

// File: tb/tb_interleaver_branch_sched.sv
// Directed bench for interleaver_branch_sched: lock, stall, realign, missed sync, async reset.
module tb_interleaver_branch_sched;
  import interleaver_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    vecs = 0;
  int    errs = 0;
  string ph = "reset";

  interleaver_branch_sched_if bus();

  interleaver_branch_sched dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s/%s got=%0h exp=%0h", ph, tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic s);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sync = s;
    @(posedge clk); #1;
  endtask

  task automatic emit_chk(input logic [7:0] d, input logic s, input int sel,
                          input logic first, input logic serr);
    drive(d, s);
    chk("valid",  32'(bus.out_valid), 1);
    chk("data",   32'(bus.out_data),  32'(d));
    chk("sel",    32'(bus.out_sel),   sel);
    chk("first",  32'(bus.out_first), 32'(first));
    chk("serr",   32'(bus.sync_err),  32'(serr));
    chk("locked", 32'(bus.locked),    1);
    chk("we",     32'(bus.branch_we), 32'(1) << sel);
  endtask

  task automatic drop_chk(input logic [7:0] d, input logic s);
    drive(d, s);
    chk("drop_valid",  32'(bus.out_valid), 0);
    chk("drop_we",     32'(bus.branch_we), 0);
    chk("drop_serr",   32'(bus.sync_err),  0);
    chk("drop_locked", 32'(bus.locked),    0);
  endtask

  function automatic logic [7:0] dv(input int j);
    return 8'(j) ^ 8'h5A;
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sync = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  32'(bus.out_valid), 0);
    chk("rst_locked", 32'(bus.locked),    0);
    chk("rst_serr",   32'(bus.sync_err),  0);
    chk("rst_ready",  32'(bus.in_ready),  1);
    @(negedge clk); rst = 1'b0;

    ph = "t1_lock";
    for (int i = 0; i < 3*PKT_LEN; i++)
      emit_chk(8'(i*7+3), (i % PKT_LEN) == 0, i % NUM_BRANCH, (i % PKT_LEN) == 0, 1'b0);

    ph = "t3_stall";
    for (int j = 0; j < 50; j++) emit_chk(dv(j), j == 0, j % NUM_BRANCH, j == 0, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = dv(50); bus.in_sync = 1'b0;
    #1 chk("stall_inready", 32'(bus.in_ready), 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_data",  32'(bus.out_data),  32'(dv(49)));
      chk("hold_sel",   32'(bus.out_sel),   1);
      chk("hold_we",    32'(bus.branch_we), 0);
      chk("hold_ready", 32'(bus.in_ready),  0);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("resume_data", 32'(bus.out_data), 32'(dv(50)));
    chk("resume_sel",  32'(bus.out_sel),  2);
    for (int j = 51; j < PKT_LEN; j++) emit_chk(dv(j), 1'b0, j % NUM_BRANCH, 1'b0, 1'b0);

    ph = "t4_realign";
    for (int j = 0; j < 100; j++) emit_chk(dv(j), j == 0, j % NUM_BRANCH, j == 0, 1'b0);
    emit_chk(dv(100), 1'b1, 0, 1'b1, 1'b1);
    for (int r = 1; r < PKT_LEN; r++) emit_chk(dv(r), 1'b0, r % NUM_BRANCH, 1'b0, 1'b0);
    emit_chk(dv(0), 1'b1, 0, 1'b1, 1'b0);
    for (int r = 1; r < PKT_LEN; r++) emit_chk(dv(r), 1'b0, r % NUM_BRANCH, 1'b0, 1'b0);

    ph = "t5_miss";
`ifdef INTLV_SYNC_FLYWHEEL_EN
    for (int m = 1; m < MAX_MISS; m++) begin
      emit_chk(dv(m), 1'b0, 0, 1'b1, 1'b0);
      for (int r = 1; r < PKT_LEN; r++) emit_chk(dv(r), 1'b0, r % NUM_BRANCH, 1'b0, 1'b0);
    end
`endif
    drop_chk(dv(0), 1'b0);

    ph = "t2_hunt";
    for (int k = 0; k < 5; k++) drop_chk(8'(k+1), 1'b0);
    emit_chk(dv(0), 1'b1, 0, 1'b1, 1'b0);
    for (int r = 1; r <= 37; r++) emit_chk(dv(r), 1'b0, r % NUM_BRANCH, 1'b0, 1'b0);

    ph = "t6_async_rst";
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid",  32'(bus.out_valid), 0);
    chk("arst_data",   32'(bus.out_data),  0);
    chk("arst_sel",    32'(bus.out_sel),   0);
    chk("arst_first",  32'(bus.out_first), 0);
    chk("arst_locked", 32'(bus.locked),    0);
    chk("arst_we",     32'(bus.branch_we), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drop_chk(8'h11, 1'b0);
    drop_chk(8'h22, 1'b0);
    emit_chk(8'h47, 1'b1, 0, 1'b1, 1'b0);
    emit_chk(8'h48, 1'b0, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
